// File: rtl/sys_array_pkg.sv
// Shared types and constants for the systolic-array feeder and its neighbours.
package sys_array_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned PROP_WIDTH         = 2 * DEFAULT_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/sys_array_feeder_if.sv
// Feeder bus: buffer/run controls from upstream, cell-facing stream and status back.
interface sys_array_feeder_if
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    clr;
  logic                    start;
  logic [DATA_WIDTH-1:0]   par_in;
  logic [2*DATA_WIDTH-1:0] prop_bias;

  logic                    param_load;
  logic [DATA_WIDTH-1:0]   param_data;
  logic [DATA_WIDTH-1:0]   input_data;
  logic [2*DATA_WIDTH-1:0] prop_data;
  logic                    in_valid;
  logic                    busy;
  logic                    done;
  logic [CW-1:0]           count;
  logic                    full;

  // Upstream side: issues writes and run requests, observes the stream.
  modport master (
    output wr_en, wr_data, clr, start, par_in, prop_bias,
    input  param_load, param_data, input_data, prop_data, in_valid, busy, done, count, full
  );

  // Feeder side.
  modport slave (
    input  wr_en, wr_data, clr, start, par_in, prop_bias,
    output param_load, param_data, input_data, prop_data, in_valid, busy, done, count, full
  );

endinterface

// File: rtl/feeder_buffer.sv
// Sample register file; the write pointer is the fill count, reads are random access.
module feeder_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  localparam int unsigned AW        = $clog2(DEPTH),
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,    // already qualified: never asserted while full
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  clr,
  input  logic [AW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         count,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         count_q;
  logic                  full_q;

  // Storage carries no reset; only the fill state is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[count_q[AW-1:0]] <= wr_data;
    end
  end

  // Fill count and registered full flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else if (wr_en) begin
      count_q <= count_q + CW'(1);
      full_q  <= (count_q == CW'(DEPTH - 1));
    end
  end

  assign rd_data = mem[rd_idx];
  assign count   = count_q;
  assign full    = full_q;

endmodule

// File: rtl/sys_array_feeder.sv
// Run sequencer: one parameter strobe, then a gap-free sample burst, drain, done.
module sys_array_feeder
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PIPE_LAT   = 1
) (
  input logic               clk,
  input logic               reset_n,
  sys_array_feeder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  feeder_state_t state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PW-1:0] bias_q;

  logic [CW-1:0]         count, count_nxt;
  logic                  full, wr_ok, clr_ok, start_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  param_load_q, in_valid_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] param_data_q, input_data_q;
  logic [PW-1:0]         prop_data_q;

  // Buffer edits only in IDLE; clr beats a same-cycle write.
  assign clr_ok    = bus.clr && (state_q == IDLE);
  assign wr_ok     = bus.wr_en && (state_q == IDLE) && !full && !bus.clr;
  // A start sees the count including any write landing in the same cycle.
  assign count_nxt = clr_ok ? '0 : count + CW'(wr_ok);
  assign start_ok  = bus.start && (state_q == IDLE) && (count_nxt != '0);

  feeder_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buffer (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_ok),
    .wr_data (bus.wr_data),
    .clr     (clr_ok),
    .rd_idx  (idx_d),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  // Next-state logic; count is frozen during a run since writes are IDLE-only.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: state_d = STREAM;
      STREAM: begin
        if (CW'(idx_q) == count - CW'(1)) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(PIPE_LAT - 1)) begin
          state_d = DONE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counters and run-time bias capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dcnt_q  <= '0;
      bias_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      if (start_ok) begin
        bias_q <= bus.prop_bias;
      end
    end
  end

  // Outputs registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      param_load_q <= 1'b0;
      param_data_q <= '0;
      input_data_q <= '0;
      prop_data_q  <= '0;
      in_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      param_load_q <= (state_d == LOAD);
      if (start_ok) begin
        param_data_q <= bus.par_in;
      end
      if (state_d == STREAM) begin
        input_data_q <= rd_data;
      end
      prop_data_q <= (state_d == STREAM) ? bias_q : '0;
      in_valid_q  <= (state_d == STREAM);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign bus.param_load = param_load_q;
  assign bus.param_data = param_data_q;
  assign bus.input_data = input_data_q;
  assign bus.prop_data  = prop_data_q;
  assign bus.in_valid   = in_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.count      = count;
  assign bus.full       = full;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed, table-driven bench for sys_array_feeder (DATA_WIDTH 8, DEPTH 4, PIPE_LAT 1).
module tb_sys_array_feeder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  sys_array_feeder_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();

  sys_array_feeder #(
    .DATA_WIDTH (8),
    .DEPTH      (4),
    .PIPE_LAT   (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic        pl;
    logic [7:0]  pd;
    logic [7:0]  id;
    logic [15:0] pr;
    logic        v;
    logic        b;
    logic        d;
    logic [2:0]  c;
    logic        f;
  } out_t;

  typedef struct packed {
    logic        w;
    logic [7:0]  wd;
    logic        c;
    logic        s;
    logic [7:0]  p;
    logic [15:0] bias;
    out_t        exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic [7:0] wd, logic c, logic s, logic [7:0] p,
                              logic [15:0] bias, logic pl, logic [7:0] pd, logic [7:0] id,
                              logic [15:0] pr, logic v, logic b, logic d, logic [2:0] cnt,
                              logic f);
    vec_t r;
    r.w = w; r.wd = wd; r.c = c; r.s = s; r.p = p; r.bias = bias;
    r.exp = '{pl: pl, pd: pd, id: id, pr: pr, v: v, b: b, d: d, c: cnt, f: f};
    return r;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = '{pl: bus.param_load, pd: bus.param_data, id: bus.input_data, pr: bus.prop_data,
          v: bus.in_valid, b: bus.busy, d: bus.done, c: bus.count, f: bus.full};
    return o;
  endfunction

  task automatic drive(logic w, logic [7:0] wd, logic c, logic s, logic [7:0] p,
                       logic [15:0] bias);
    bus.wr_en = w; bus.wr_data = wd; bus.clr = c; bus.start = s;
    bus.par_in = p; bus.prop_bias = bias;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, out_t exp);
    out_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pl=%0d pd=%h id=%h pr=%h v=%0d b=%0d d=%0d c=%0d f=%0d, want pl=%0d pd=%h id=%h pr=%h v=%0d b=%0d d=%0d c=%0d f=%0d",
               name, act.pl, act.pd, act.id, act.pr, act.v, act.b, act.d, act.c, act.f,
               exp.pl, exp.pd, exp.id, exp.pr, exp.v, exp.b, exp.d, exp.c, exp.f);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
    $fatal(1);
  end

  initial begin
    out_t zero;
    zero = '0;

    // Columns: wr_en wr_data clr start par bias | pl pd id pr v busy done count full
    // Basic run: 3,5,7 with PIPE_LAT 1.
    tbl.push_back(mk(1, 8'd3, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'd5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 8'd7, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'd2, 0,  1, 2, 0, 0, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 2, 3, 0, 1, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 2, 5, 0, 1, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 2, 7, 0, 1, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 2, 7, 0, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 2, 7, 0, 0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,     0, 2, 7, 0, 0, 0, 0, 3, 0));
    // Replay with bias; start/wr_en/par/bias changes during the run are ignored.
    tbl.push_back(mk(0, 0, 0, 1, 8'd9, 16'h0100,        1, 9, 7, 0, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                  0, 9, 3, 16'h0100, 1, 1, 0, 3, 0));
    tbl.push_back(mk(1, 8'hAA, 0, 1, 8'h55, 16'hFFFF,   0, 9, 5, 16'h0100, 1, 1, 0, 3, 0));
    tbl.push_back(mk(1, 8'hBB, 0, 0, 0, 0,              0, 9, 7, 16'h0100, 1, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                  0, 9, 7, 0, 0, 1, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h77, 0,              0, 9, 7, 0, 0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                  0, 9, 7, 0, 0, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,                  0, 9, 7, 0, 0, 0, 0, 3, 0));
    // Fill to DEPTH; fifth write dropped and never streamed.
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 0,  0, 9, 7, 0, 0, 0, 0, 4, 1));
    tbl.push_back(mk(1, 8'h22, 0, 0, 0, 0,  0, 9, 7, 0, 0, 0, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 1, 8'd1, 0,   1, 1, 7, 0, 0, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 1, 3, 0, 1, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 1, 5, 0, 1, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 1, 7, 0, 1, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 1, 8'h11, 0, 1, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 1, 8'h11, 0, 0, 1, 0, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 1, 8'h11, 0, 0, 1, 1, 4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 1, 8'h11, 0, 0, 0, 0, 4, 1));
    // clr wins over wr_en; start on empty buffer ignored; start+write runs one sample.
    tbl.push_back(mk(1, 8'h33, 1, 0, 0, 0,  0, 1, 8'h11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 8'h66, 0,  0, 1, 8'h11, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h44, 0, 1, 8'd6, 0, 1, 6, 8'h11, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 6, 8'h44, 0, 1, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 6, 8'h44, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 6, 8'h44, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,      0, 6, 8'h44, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 8'h55, 0, 0, 0, 0,  0, 6, 8'h44, 0, 0, 0, 0, 2, 0));

    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("reset", zero);

    foreach (tbl[i]) begin
      drive(tbl[i].w, tbl[i].wd, tbl[i].c, tbl[i].s, tbl[i].p, tbl[i].bias);
      tick();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Reset during the second stream sample: everything clears without a clock edge.
    drive(0, 0, 0, 1, 8'd3, 16'h0200);
    tick();
    check("rst_load", mk(0, 0, 0, 0, 0, 0, 1, 3, 8'h44, 0, 0, 1, 0, 2, 0).exp);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("rst_s0", mk(0, 0, 0, 0, 0, 0, 0, 3, 8'h44, 16'h0200, 1, 1, 0, 2, 0).exp);
    tick();
    check("rst_s1", mk(0, 0, 0, 0, 0, 0, 0, 3, 8'h55, 16'h0200, 1, 1, 0, 2, 0).exp);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", zero);
    tick();
    check("rst_hold", zero);
    reset_n = 1'b1;

    // Empty after reset: start ignored, no busy/done over several cycles.
    drive(0, 0, 0, 1, 8'h0A, 0);
    tick();
    check("post_rst_start", zero);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_rst_idle%0d", k), zero);
    end
    drive(1, 8'h66, 0, 0, 0, 0);
    tick();
    check("post_rst_wr", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0).exp);
    drive(0, 0, 0, 1, 8'h0A, 0);
    tick();
    check("post_rst_run", mk(0, 0, 0, 0, 0, 0, 1, 8'h0A, 0, 0, 0, 1, 0, 1, 0).exp);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("post_rst_s0", mk(0, 0, 0, 0, 0, 0, 0, 8'h0A, 8'h66, 0, 1, 1, 0, 1, 0).exp);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
